// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
//   state_e        : loader FSM states
//   BYTES_PER_WORD : stream bytes packed into one instruction word
//   HDR_BYTES      : frame header length (16-bit little-endian word count)
package imem_boot_pkg;

  localparam int unsigned IMEM_WORD_W    = 32;
  localparam int unsigned BYTES_PER_WORD = IMEM_WORD_W / 8;
  localparam int unsigned HDR_BYTES      = 2;

  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StData,
    StCsum,
    StFill,
    StDone,
    StError
  } state_e;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream and instruction-memory write bus of the boot loader.
//   byte_valid/byte_data/byte_ready : framed byte stream (valid/ready handshake)
//   imem_we/imem_addr/imem_wdata    : word write port into instruction memory
// slave  = loader side, master = stream source which also observes the memory writes.
interface imem_boot_loader_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WORD_W = 32
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_word_packer.sv
// Packs stream bytes little-endian into instruction words.
//   clk_i, rst_i   : clock, async active-high reset
//   clr_i          : restart packing at a frame start
//   push_i         : accept byte_i this cycle
//   last_o         : the next pushed byte completes a word
//   word_valid_o   : one-cycle pulse the cycle after a word completes
//   word_o         : packed word, valid while word_valid_o is high
module imem_word_packer
  import imem_boot_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [7:0]        byte_i,
  output logic              last_o,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] word_o
);

  logic [1:0]        idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;

  assign last_o       = (idx_q == 2'(BYTES_PER_WORD - 1));
  assign word_valid_o = valid_q;
  assign word_o       = word_q;

  // Bytes enter at the top and shift down, so the first byte ends up in the LSBs.
  always_comb begin
    idx_d   = idx_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clr_i) begin
      idx_d  = '0;
      word_d = '0;
    end else if (push_i) begin
      word_d  = {byte_i, word_q[WORD_W-1:8]};
      idx_d   = idx_q + 2'd1;
      valid_d = last_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Hardware boot loader for the CPU instruction memory.
// Receives a frame {LEN_LO, LEN_HI, 4*N payload bytes, XOR checksum}, writes the payload
// words from address 0, zero-fills the rest of memory and releases the CPU on success.
//   clk_i, rst_i   : clock, async active-high reset
//   load_req_i     : start pulse, honoured in idle/done/error
//   bus_io         : byte stream in, instruction-memory writes out
//   cpu_rst_o      : CPU held in reset unless a load completed successfully
//   cpu_start_o    : CPU start after a good load
//   busy_o/done_o/err_o : load status
//   words_loaded_o : word count N from the last accepted header
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_req_i,
  imem_boot_loader_if.slave bus_io,
  output logic              cpu_rst_o,
  output logic              cpu_start_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   words_loaded_o
);

  localparam logic [ADDR_W:0] Depth = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] One   = (ADDR_W + 1)'(1);

  state_e          state_q, state_d;
  logic [7:0]      len_lo_q, len_lo_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] wcnt_q, wcnt_d;  // payload words received
  logic [ADDR_W:0] cnt_q, cnt_d;    // next write address; one extra bit so it never wraps
  logic [7:0]      csum_q, csum_d;

  logic              ready;
  logic              fire;
  logic              start;
  logic              we;
  logic              oversize;
  logic [15:0]       len16;
  logic              pk_last;
  logic              pk_valid;
  logic [WORD_W-1:0] pk_word;

  assign fire     = bus_io.byte_valid && ready;
  assign start    = load_req_i && (state_q inside {StIdle, StDone, StError});
  assign len16    = {bus_io.byte_data, len_lo_q};
  assign oversize = (|len16[15:ADDR_W+1]) || (len16[ADDR_W:0] > Depth);

  imem_word_packer #(
    .WORD_W (WORD_W)
  ) u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (start),
    .push_i       (fire && (state_q == StData)),
    .byte_i       (bus_io.byte_data),
    .last_o       (pk_last),
    .word_valid_o (pk_valid),
    .word_o       (pk_word)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StError: if (start) state_d = StHdr0;
      StHdr0: if (fire) state_d = StHdr1;
      StHdr1: begin
        if (fire) begin
          if (oversize)                    state_d = StError;
          else if (len16[ADDR_W:0] == '0)  state_d = StCsum;
          else                             state_d = StData;
        end
      end
      StData: if (fire && pk_last && (wcnt_q == len_q - One)) state_d = StCsum;
      StCsum: begin
        if (fire) begin
          if (bus_io.byte_data != csum_q) state_d = StError;
          else if (len_q == Depth)        state_d = StDone;
          else                            state_d = StFill;
        end
      end
      StFill: if (cnt_q == Depth - One) state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // The last payload write lands in CSUM, so FILL always starts at address N.
  always_comb begin
    ready       = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    cpu_rst_o   = 1'b1;
    cpu_start_o = 1'b0;
    unique case (state_q)
      StHdr0, StHdr1, StData, StCsum: begin
        ready  = 1'b1;
        busy_o = 1'b1;
      end
      StFill: busy_o = 1'b1;
      StDone: begin
        done_o      = 1'b1;
        cpu_rst_o   = 1'b0;
        cpu_start_o = 1'b1;
      end
      StError: err_o = 1'b1;
      default: ;
    endcase
    we = pk_valid || (state_q == StFill);
  end

  assign bus_io.byte_ready = ready;
  assign bus_io.imem_we    = we;
  assign bus_io.imem_addr  = cnt_q[ADDR_W-1:0];
  assign bus_io.imem_wdata = (state_q == StFill) ? '0 : pk_word;
  assign words_loaded_o    = len_q;

  always_comb begin
    len_lo_d = len_lo_q;
    len_d    = len_q;
    wcnt_d   = wcnt_q;
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    if (start) begin
      wcnt_d = '0;
      cnt_d  = '0;
      csum_d = '0;
    end else begin
      if (fire) begin
        unique case (state_q)
          StHdr0: len_lo_d = bus_io.byte_data;
          StHdr1: len_d    = len16[ADDR_W:0];
          StData: begin
            csum_d = csum_q ^ bus_io.byte_data;
            if (pk_last) wcnt_d = wcnt_q + One;
          end
          default: ;
        endcase
      end
      if (we) cnt_d = cnt_q + One;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_lo_q <= '0;
      len_q    <= '0;
      wcnt_q   <= '0;
      cnt_q    <= '0;
      csum_q   <= '0;
    end else begin
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      wcnt_q   <= wcnt_d;
      cnt_q    <= cnt_d;
      csum_q   <= csum_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned WORD_W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_req = 1'b0;
  logic        cpu_rst, cpu_start, busy, done, err;
  logic [8:0]  words_loaded;

  imem_boot_loader_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

  imem_boot_loader #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .load_req_i     (load_req),
    .bus_io         (bus),
    .cpu_rst_o      (cpu_rst),
    .cpu_start_o    (cpu_start),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err),
    .words_loaded_o (words_loaded)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory image and write count seen on the write port.
  logic [31:0] mem [256];
  int          wr_cnt = 0;
  logic        mon_clr = 1'b0;

  always @(posedge clk) begin
    if (mon_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hDEADBEEF;
      wr_cnt <= 0;
    end else if (bus.imem_we) begin
      mem[bus.imem_addr] <= bus.imem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  logic [7:0] pay [1024];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_req(input bit clr);
    @(negedge clk);
    load_req = 1'b1;
    mon_clr  = clr;
    @(negedge clk);
    load_req = 1'b0;
    mon_clr  = 1'b0;
  endtask

  // Called and returns at a negedge; checks the write the cycle after a 4th byte.
  task automatic send_byte(input logic [7:0] b, input bit last, input logic [7:0] a,
                           input logic [31:0] w);
    int t = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("byte_accept_timeout", 32'(t < 50), 32'd1);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    if (last) begin
      check("wr_latency_we", 32'(bus.imem_we), 32'd1);
      check("wr_addr", 32'(bus.imem_addr), 32'(a));
      check("wr_data", bus.imem_wdata, w);
    end
  endtask

  task automatic send_frame(input int n, input logic [7:0] cs, input bit thr);
    logic [31:0] w;
    send_byte(8'(n), 1'b0, 8'd0, 32'd0);
    send_byte(8'(n >> 8), 1'b0, 8'd0, 32'd0);
    for (int k = 0; k < 4 * n; k++) begin
      if (thr) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (k == 3) repeat (10) @(negedge clk);
      end
      w = 32'd0;
      if (k % 4 == 3) w = {pay[k], pay[k-1], pay[k-2], pay[k-3]};
      send_byte(pay[k], (k % 4 == 3), 8'(k / 4), w);
    end
    send_byte(cs, 1'b0, 8'd0, 32'd0);
  endtask

  task automatic wait_end();
    int t = 0;
    while (!(done || err) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("end_timeout", 32'(t < 1000), 32'd1);
  endtask

  task automatic load_good_frame();
    pay[0] = 8'h13; pay[1] = 8'h00; pay[2] = 8'h50; pay[3] = 8'h00;
    pay[4] = 8'h93; pay[5] = 8'h00; pay[6] = 8'hA0; pay[7] = 8'h00;
  endtask

  task automatic check_good_image(input string tag);
    bit ok = 1'b1;
    for (int i = 2; i < 256; i++) if (mem[i] !== 32'd0) ok = 1'b0;
    check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd256);
    check({tag, "_mem0"}, mem[0], 32'h00500013);
    check({tag, "_mem1"}, mem[1], 32'h00A00093);
    check({tag, "_fill_zero"}, 32'(ok), 32'd1);
    check({tag, "_done"}, {27'd0, done, err, cpu_start, cpu_rst, busy}, 32'b10100);
    check({tag, "_words"}, 32'(words_loaded), 32'd2);
  endtask

  initial begin
    logic [7:0] cs;
    bit         ok;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_status", {27'd0, done, err, cpu_start, cpu_rst, busy}, 32'b00010);
    check("rst_ready_we", {30'd0, bus.byte_ready, bus.imem_we}, 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    rst = 1'b0;

    // Byte offered in IDLE is not taken
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hAA;
    repeat (3) @(negedge clk);
    check("idle_ready", 32'(bus.byte_ready), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    bus.byte_valid = 1'b0;

    // Good load
    load_good_frame();
    pulse_req(1'b1);
    check("req_busy", {30'd0, busy, cpu_rst}, 32'b11);
    send_frame(2, 8'h70, 1'b0);
    wait_end();
    check_good_image("good");

    // load_req in DONE re-asserts CPU reset next cycle
    pulse_req(1'b1);
    check("redo_status", {27'd0, done, err, cpu_start, cpu_rst, busy}, 32'b00011);

    // Bad checksum
    send_frame(2, 8'h71, 1'b0);
    wait_end();
    check("badcs_status", {27'd0, done, err, cpu_start, cpu_rst, busy}, 32'b01010);
    check("badcs_wr_cnt", 32'(wr_cnt), 32'd2);

    // Oversize header
    pulse_req(1'b1);
    send_byte(8'h01, 1'b0, 8'd0, 32'd0);
    send_byte(8'h01, 1'b0, 8'd0, 32'd0);
    check("over_status", {27'd0, done, err, cpu_start, cpu_rst, busy}, 32'b01010);
    check("over_ready", 32'(bus.byte_ready), 32'd0);
    check("over_words", 32'(words_loaded), 32'd257);
    repeat (3) @(negedge clk);
    check("over_wr_cnt", 32'(wr_cnt), 32'd0);

    // N = 0: all zero fill
    pulse_req(1'b1);
    send_frame(0, 8'h00, 1'b0);
    wait_end();
    ok = 1'b1;
    for (int i = 0; i < 256; i++) if (mem[i] !== 32'd0) ok = 1'b0;
    check("n0_wr_cnt", 32'(wr_cnt), 32'd256);
    check("n0_zero", 32'(ok), 32'd1);
    check("n0_done", {30'd0, done, cpu_start}, 32'b11);
    check("n0_words", 32'(words_loaded), 32'd0);

    // N = 256: full payload, no fill
    cs = 8'h00;
    for (int k = 0; k < 1024; k++) begin
      pay[k] = 8'((k / 4) * 7 + (k % 4) * 61 + 3);
      cs = cs ^ pay[k];
    end
    pulse_req(1'b1);
    send_frame(256, cs, 1'b0);
    wait_end();
    ok = 1'b1;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== {pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]}) ok = 1'b0;
    check("n256_wr_cnt", 32'(wr_cnt), 32'd256);
    check("n256_image", 32'(ok), 32'd1);
    check("n256_done", {30'd0, done, cpu_rst}, 32'b10);
    check("n256_words", 32'(words_loaded), 32'd256);

    // Throttled stream
    load_good_frame();
    pulse_req(1'b1);
    send_frame(2, 8'h70, 1'b1);
    wait_end();
    check_good_image("thr");

    // Asynchronous reset mid-DATA
    pulse_req(1'b1);
    send_byte(8'h02, 1'b0, 8'd0, 32'd0);
    send_byte(8'h00, 1'b0, 8'd0, 32'd0);
    send_byte(8'h13, 1'b0, 8'd0, 32'd0);
    send_byte(8'h00, 1'b0, 8'd0, 32'd0);
    check("mid_ready", 32'(bus.byte_ready), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_status", {27'd0, done, err, cpu_start, cpu_rst, busy}, 32'b00010);
    check("arst_ready", 32'(bus.byte_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Good load with a load_req pulsed while busy
    load_good_frame();
    pulse_req(1'b1);
    send_byte(8'h02, 1'b0, 8'd0, 32'd0);
    send_byte(8'h00, 1'b0, 8'd0, 32'd0);
    send_byte(8'h13, 1'b0, 8'd0, 32'd0);
    pulse_req(1'b0);
    check("busy_req_ignored", 32'(busy), 32'd1);
    send_byte(8'h00, 1'b0, 8'd0, 32'd0);
    send_byte(8'h50, 1'b0, 8'd0, 32'd0);
    send_byte(8'h00, 1'b1, 8'd0, 32'h00500013);
    send_byte(8'h93, 1'b0, 8'd0, 32'd0);
    send_byte(8'h00, 1'b0, 8'd0, 32'd0);
    send_byte(8'hA0, 1'b0, 8'd0, 32'd0);
    send_byte(8'h00, 1'b1, 8'd1, 32'h00A00093);
    send_byte(8'h70, 1'b0, 8'd0, 32'd0);
    wait_end();
    check_good_image("after_rst");

    // load_req in DONE returns cpu_rst to 1
    pulse_req(1'b0);
    check("done_req_cpu_rst", {30'd0, cpu_rst, cpu_start}, 32'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Hardware-side writer for the CPU instruction memory; replaces the simulation-only file preload.
- Accepts a framed byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit words.
- Writes the words sequentially into instruction memory, zero-fills the remainder and checks an XOR checksum.
- Holds the CPU in reset during load; releases it and raises start only after a good load.

Parameters:
- ADDR_W, 8, instruction-memory word-address width (depth = 2^ADDR_W = 256 words).
- WORD_W, 32, instruction word width; fixed at 32, which must be a multiple of 8.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- load_req_i  in  1  one-cycle pulse that starts a load; honoured only in IDLE, DONE or ERROR.
- byte_valid_i  in  1  stream byte valid.
- byte_data_i  in  8  stream byte.
- byte_ready_o  out  1  loader accepts a byte this cycle.
- imem_we_o  out  1  instruction-memory write strobe.
- imem_addr_o  out  ADDR_W  word address.
- imem_wdata_o  out  WORD_W  write data.
- cpu_rst_o  out  1  CPU reset; high = CPU held in reset.
- cpu_start_o  out  1  CPU start.
- busy_o  out  1  load in progress.
- done_o  out  1  last load succeeded.
- err_o  out  1  last load failed.
- words_loaded_o  out  ADDR_W+1  payload word count N of the last accepted header.

Behaviour:
- Reset values (asynchronous, active-high):
  - State = IDLE.
  - cpu_rst_o = 1.
  - All other outputs = 0.
- Frame format, in byte order:
  - Header: LEN_LO, LEN_HI, giving N as 16-bit little-endian.
  - Payload: 4*N bytes, each word's least-significant byte first.
  - CSUM: one byte, equal to the XOR of all payload bytes.
- Handshake:
  - A byte transfers when byte_valid_i && byte_ready_o.
  - byte_ready_o = 1 only in HDR0, HDR1, DATA and CSUM.
  - byte_ready_o is a registered state decode: it must not depend combinationally on byte_valid_i.
- State machine:
  - IDLE: on load_req_i go to HDR0. Clear the checksum, address counter, byte counter and done/err. Set busy_o = 1 and cpu_rst_o = 1.
  - HDR0: capture LEN_LO on transfer, then go to HDR1.
  - HDR1: capture LEN_HI on transfer.
    - N > 2^ADDR_W: go to ERROR.
    - N == 0: go to CSUM.
    - Otherwise: go to DATA.
    - words_loaded_o updates on this transfer in all cases.
  - DATA: each transfer shifts into the word packer and XORs into the checksum.
    - On the 4th byte of a word, the next cycle drives imem_we_o = 1 for exactly one cycle, with imem_addr_o = current word address and imem_wdata_o = the packed word. The address then increments.
    - Write latency: 1 cycle from the 4th-byte handshake.
    - After word N-1 is accepted, go to CSUM.
  - CSUM: on transfer, compare the received byte with the running XOR.
    - Match: go to FILL.
    - Mismatch: go to ERROR.
  - FILL: one write per cycle with imem_wdata_o = 0, at addresses N through 2^ADDR_W-1, byte_ready_o = 0.
    - When N == 2^ADDR_W, FILL lasts 0 cycles and goes directly to DONE.
  - DONE: busy_o = 0, done_o = 1, cpu_rst_o = 0, cpu_start_o = 1. Stay until load_req_i, which behaves as in IDLE and re-asserts cpu_rst_o in the next cycle.
  - ERROR: busy_o = 0, err_o = 1, cpu_rst_o = 1, cpu_start_o = 0. Stay until load_req_i, which behaves as in IDLE.
- Boundary conditions:
  - load_req_i while busy is ignored.
  - byte_valid_i outside a ready state is ignored, and the byte is not consumed.
  - Gaps in byte_valid_i mid-word or mid-header stall the machine without losing state.
  - The address counter never wraps: N is bounded at HDR1, and FILL stops at the last address.
  - Reset mid-load returns immediately to the reset values. Memory contents are then undefined, but cpu_rst_o = 1 protects the CPU.
- Arithmetic:
  - Word address is ADDR_W bits.
  - The N comparison uses ADDR_W+1 bits.
  - The upper LEN bits must all be zero for N to be accepted.

Decomposition:
- Package imem_boot_pkg holds:
  - The state enum (IDLE, HDR0, HDR1, DATA, CSUM, FILL, DONE, ERROR).
  - BYTES_PER_WORD = WORD_W/8.
  - HDR_BYTES = 2.
- Sub-module imem_word_packer:
  - Contains the byte shift register, the 2-bit byte index and a word_valid pulse.
  - Has a clear input driven on frame start.
- The FSM, counters and checksum stay in the top module.

Test Plan:
- Good load: N=2, bytes 13 00 50 00, 93 00 A0 00, csum = 0x13^0x50^0x93^0xA0 = 0x70 -> writes (0, 0x00500013) then (1, 0x00A00093); zeros at 2..255; done_o = 1, cpu_start_o = 1, cpu_rst_o = 0, words_loaded_o = 2.
- Bad checksum: same frame with csum = 0x71 -> no FILL writes; err_o = 1, cpu_rst_o = 1, cpu_start_o = 0.
- Oversize header: LEN = 0x0101 (257) -> ERROR directly after HDR1; no writes; byte_ready_o = 0 after the header.
- N = 0 with csum 0x00 -> 256 zero writes at addresses 0..255, then DONE. Separately, N = 256 with a correct csum -> 256 payload writes, no FILL writes, DONE.
- Throttled stream: byte_valid_i toggled randomly, plus a 10-cycle gap between bytes 2 and 3 of word 0 -> same writes as the good-load case; each write occurs exactly 1 cycle after its 4th-byte handshake.
- Reset asserted mid-DATA -> outputs return to reset values asynchronously. Then:
  - load_req_i during busy is ignored.
  - A subsequent full good load from IDLE succeeds.
  - load_req_i in DONE returns cpu_rst_o to 1.
